// File: rtl/render_pixel_scanner.sv
// Raster coordinate generator: walks the render buffer row-major, emits (x,y)
// over valid/ready, pulses frame_done_out and counts completed frames.
//
// Ports:
//   clk_in, rst_n_in (async active-low)   clock / reset
//   start_in                              frame start request (1 cycle)
//   ready_in                              downstream accepts coordinate
//   x_out[10:0], y_out[9:0], valid_out    coordinate beat
//   busy_out                              high while scanning or done
//   frame_done_out                        1-cycle pulse after last beat
//   frame_count_out[7:0]                  completed frames, wraps
//
// Build option: define SCAN_INTERLACE_EN for alternating even/odd fields.
module render_pixel_scanner #(
    parameter int WIDTH  = 512,
    parameter int HEIGHT = 384
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        start_in,
    input  logic        ready_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        valid_out,
    output logic        busy_out,
    output logic        frame_done_out,
    output logic [7:0]  frame_count_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [10:0] X_LAST = 11'(WIDTH - 1);

    logic [1:0]  state;
    logic [10:0] x_q;
    logic [9:0]  y_q;
    logic        pending;
    logic [7:0]  count_q;

    logic [9:0]  row_first;
    logic [9:0]  row_last;
    logic [9:0]  row_step;
    logic        last_x;
    logic        last_y;

`ifdef SCAN_INTERLACE_EN
    // Field parity is latched at frame start so the last-row compare
    // stays fixed while the frame counter moves on.
    logic parity_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            parity_q <= 1'b0;
        end else if ((state == S_IDLE && start_in) || state == S_DONE) begin
            parity_q <= count_q[0];
        end
    end

    assign row_first = {9'd0, count_q[0]};
    assign row_last  = 10'(HEIGHT - 2) + {9'd0, parity_q};
    assign row_step  = 10'd2;
`else
    assign row_first = 10'd0;
    assign row_last  = 10'(HEIGHT - 1);
    assign row_step  = 10'd1;
`endif

    assign last_x = (x_q == X_LAST);
    assign last_y = (y_q == row_last);

    // The frame counter steps on the last transfer edge so the new value
    // is already visible during the done pulse.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state   <= S_IDLE;
            x_q     <= 11'd0;
            y_q     <= 10'd0;
            pending <= 1'b0;
            count_q <= 8'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start_in) begin
                        state <= S_SCAN;
                        x_q   <= 11'd0;
                        y_q   <= row_first;
                    end
                end
                S_SCAN: begin
                    if (start_in) begin
                        pending <= 1'b1;
                    end
                    if (ready_in) begin
                        if (last_x) begin
                            x_q <= 11'd0;
                            if (last_y) begin
                                state   <= S_DONE;
                                count_q <= count_q + 8'd1;
                            end else begin
                                y_q <= y_q + row_step;
                            end
                        end else begin
                            x_q <= x_q + 11'd1;
                        end
                    end
                end
                S_DONE: begin
                    pending <= 1'b0;
                    if (pending || start_in) begin
                        state <= S_SCAN;
                        x_q   <= 11'd0;
                        y_q   <= row_first;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign x_out           = x_q;
    assign y_out           = y_q;
    assign valid_out       = (state == S_SCAN);
    assign busy_out        = (state != S_IDLE);
    assign frame_done_out  = (state == S_DONE);
    assign frame_count_out = count_q;

endmodule

// File: tb/tb_render_pixel_scanner.sv
// Scoreboard bench for render_pixel_scanner on a small 8x4 buffer.
// Expected beats are queued at start time and popped on each transfer.
module tb_render_pixel_scanner;

    localparam int W = 8;
    localparam int H = 4;
`ifdef SCAN_INTERLACE_EN
    localparam int RS = 2;
`else
    localparam int RS = 1;
`endif
    localparam int FB = W * H / RS;
    localparam int P  = FB + 1;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        start_in = 1'b0;
    logic        ready_in = 1'b1;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic        valid_out;
    logic        busy_out;
    logic        frame_done_out;
    logic [7:0]  frame_count_out;

    render_pixel_scanner #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .start_in        (start_in),
        .ready_in        (ready_in),
        .x_out           (x_out),
        .y_out           (y_out),
        .valid_out       (valid_out),
        .busy_out        (busy_out),
        .frame_done_out  (frame_done_out),
        .frame_count_out (frame_count_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int x;
        int y;
        bit last;
    } beat_t;

    beat_t sb[$];
    beat_t mon_e;
    int    n_vec = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    exp_count = 0;
    bit    done_flag = 0;
    bit    mon_en = 0;
    int    frames_pushed = 0;
    int    done_seen = 0;
    int    last_done_cyc = 0;
    int    start_cyc = 0;

    task automatic check(input string tag, input int got, input int want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic push_frame();
        int par;
        par = (RS == 2) ? (frames_pushed & 1) : 0;
        for (int y = par; y < H; y += RS) begin
            for (int x = 0; x < W; x++) begin
                sb.push_back('{x: x, y: y, last: (x == W - 1) && (y + RS >= H)});
            end
        end
        frames_pushed++;
    endtask

    always @(posedge clk_in) cyc++;

    always @(negedge clk_in) begin
        if (mon_en) begin
            check("done", int'(frame_done_out), int'(done_flag));
            check("count", int'(frame_count_out), exp_count);
            if (frame_done_out) begin
                done_seen++;
                last_done_cyc = cyc;
            end
            done_flag = 0;
            if (valid_out && ready_in) begin
                if (sb.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("x", int'(x_out), mon_e.x);
                    check("y", int'(y_out), mon_e.y);
                    if (mon_e.last) begin
                        exp_count = (exp_count + 1) % 256;
                        done_flag = 1;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        mon_en   = 0;
        rst_n_in = 1'b0;
        #1;
        check("rst_valid", int'(valid_out), 0);
        check("rst_busy", int'(busy_out), 0);
        check("rst_done", int'(frame_done_out), 0);
        check("rst_count", int'(frame_count_out), 0);
        check("rst_x", int'(x_out), 0);
        check("rst_y", int'(y_out), 0);
        sb.delete();
        exp_count     = 0;
        done_flag     = 0;
        frames_pushed = 0;
        start_in      = 1'b0;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        mon_en   = 1;
    endtask

    task automatic start_frame();
        @(posedge clk_in);
        #1;
        start_in = 1'b1;
        push_frame();
        @(posedge clk_in);
        #1;
        start_in = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while ((sb.size() != 0 || busy_out) && n < budget);
        if (sb.size() != 0 || busy_out) check(tag, 0, 1);
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk_in);
        do_reset();

        // single frame, ready held high, with start latency
        ready_in = 1'b1;
        start_frame();
        check("lat_valid", int'(valid_out), 1);
        check("lat_busy", int'(busy_out), 1);
        wait_idle("timeout_full", 4 * P);
        check("full_count", int'(frame_count_out), 1);
        check("full_sb", sb.size(), 0);

        // random ready stalls, about 40% low
        start_frame();
        begin
            int n;
            n = 0;
            while ((sb.size() != 0 || busy_out) && n < 40 * P) begin
                @(posedge clk_in);
                #1;
                ready_in = ($urandom_range(0, 9) >= 4);
                n++;
            end
            if (sb.size() != 0 || busy_out) check("timeout_stall", 0, 1);
        end
        ready_in = 1'b1;
        check("stall_count", int'(frame_count_out), 2);

        // restart mid-frame and on the last-transfer cycle -> one extra frame
        start_frame();
        repeat (10) @(posedge clk_in);
        #1;
        start_in = 1'b1;
        push_frame();
        @(posedge clk_in);
        #1;
        start_in = 1'b0;
        repeat (FB - 12) @(posedge clk_in);
        #1;
        start_in = 1'b1;
        @(posedge clk_in);
        #1;
        start_in = 1'b0;
        check("gap_valid", int'(valid_out), 0);
        check("gap_busy", int'(busy_out), 1);
        @(posedge clk_in);
        #1;
        check("restart_valid", int'(valid_out), 1);
        wait_idle("timeout_restart", 4 * P);
        repeat (3) @(negedge clk_in);
        check("restart_idle", int'(busy_out), 0);
        check("restart_sb", sb.size(), 0);
        check("restart_count", int'(frame_count_out), 4);

        // reset mid-frame, then a clean frame from (0,0)
        start_frame();
        repeat (13) @(posedge clk_in);
        #2;
        do_reset();
        start_frame();
        wait_idle("timeout_after_rst", 4 * P);
        check("after_rst_count", int'(frame_count_out), 1);

        // 256 back-to-back frames with start held high
        @(negedge clk_in);
        do_reset();
        done_seen = 0;
        @(posedge clk_in);
        #1;
        start_in = 1'b1;
        for (int i = 0; i < 256; i++) push_frame();
        @(posedge clk_in);
        #1;
        start_cyc = cyc;
        repeat (254 * P + 10 - 1) @(posedge clk_in);
        #1;
        start_in = 1'b0;
        wait_idle("timeout_wrap", 4 * P);
        check("wrap_count", int'(frame_count_out), 0);
        check("wrap_frames", done_seen, 256);
        check("wrap_period", last_done_cyc - start_cyc, 256 * P - 1);

        repeat (3) @(negedge clk_in);
        check("final_sb", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
